// File: rtl/motor_cmd_sequencer.sv
// motor_cmd_sequencer: turns (direction, duty, step) commands into a
// slew-limited duty/direction/enable stream for the PWM generator. Duty is
// ramped at a fixed tick rate. A reversal brakes to zero, then holds a
// dead-time with the bridge off before ramping in the new direction.
// estop overrides all of this.
module motor_cmd_sequencer #(
  parameter int DUTY_W   = 8,
  parameter int RAMP_DIV = 16,
  parameter int DEADTIME = 8
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [DUTY_W-1:0] cmd_duty,
  input  logic [DUTY_W-1:0] cmd_step,
  input  logic              estop,
  output logic [DUTY_W-1:0] pwm_duty,
  output logic              pwm_dir,
  output logic              pwm_en,
  output logic              busy,
  output logic              fault
);

  localparam int TICK_W = $clog2(RAMP_DIV);
  localparam int DEAD_W = $clog2(DEADTIME + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(RAMP_DIV - 1);
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEADTIME - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_RAMP,
    S_BRAKE,
    S_DEAD,
    S_ESTOP
  } state_t;

  state_t              state, state_nxt;
  logic [DUTY_W-1:0]   duty_nxt;
  logic                dir_nxt, en_nxt;
  logic [TICK_W-1:0]   tick_cnt, tick_nxt;
  logic [DEAD_W-1:0]   dead_cnt, dead_nxt;
  logic                tgt_dir, tgt_dir_nxt;
  logic [DUTY_W-1:0]   tgt_duty, tgt_duty_nxt;
  logic [DUTY_W-1:0]   step, step_nxt;
  logic [DUTY_W-1:0]   cmd_step_eff;
  logic [DUTY_W-1:0]   ramp_duty, brake_duty;
  logic                accept, tick;

  // Move cur one step toward tgt, landing exactly on tgt instead of
  // overshooting. The upward sum is widened by one bit so it cannot wrap.
  function automatic logic [DUTY_W-1:0] step_toward(
    input logic [DUTY_W-1:0] cur,
    input logic [DUTY_W-1:0] tgt,
    input logic [DUTY_W-1:0] stp
  );
    logic [DUTY_W:0]   up;
    logic [DUTY_W-1:0] res;
    up = {1'b0, cur} + {1'b0, stp};
    if (cur <= tgt)
      res = (up >= {1'b0, tgt}) ? tgt : up[DUTY_W-1:0];
    else
      res = ((cur - tgt) <= stp) ? tgt : (cur - stp);
    return res;
  endfunction

  // Decrement by stp, floored at zero.
  function automatic logic [DUTY_W-1:0] floor_sub(
    input logic [DUTY_W-1:0] cur,
    input logic [DUTY_W-1:0] stp
  );
    return (cur <= stp) ? '0 : (cur - stp);
  endfunction

  assign cmd_ready    = ((state == S_IDLE) || (state == S_RUN)) && !estop && !ARESET;
  assign accept       = cmd_valid && cmd_ready;
  assign cmd_step_eff = (cmd_step == '0) ? DUTY_W'(1) : cmd_step;
  assign tick         = (tick_cnt == TICK_LAST);
  assign ramp_duty    = step_toward(pwm_duty, tgt_duty, step);
  assign brake_duty   = floor_sub(pwm_duty, step);
  assign busy         = (state == S_RAMP) || (state == S_BRAKE) || (state == S_DEAD);
  assign fault        = (state == S_ESTOP);

  // Next-state and next-output logic; estop wins over any command or ramp.
  always_comb begin
    state_nxt    = state;
    duty_nxt     = pwm_duty;
    dir_nxt      = pwm_dir;
    en_nxt       = pwm_en;
    tick_nxt     = tick_cnt;
    dead_nxt     = dead_cnt;
    tgt_dir_nxt  = tgt_dir;
    tgt_duty_nxt = tgt_duty;
    step_nxt     = step;
    if (estop) begin
      state_nxt = S_ESTOP;
      duty_nxt  = '0;
      en_nxt    = 1'b0;
    end else begin
      if (accept) begin
        tgt_dir_nxt  = cmd_dir;
        tgt_duty_nxt = cmd_duty;
        step_nxt     = cmd_step_eff;
      end
      case (state)
        S_IDLE: begin
          duty_nxt = '0;
          en_nxt   = 1'b0;
          if (accept && (cmd_duty != '0)) begin
            if (cmd_dir != pwm_dir) begin
              state_nxt = S_DEAD;
              dead_nxt  = '0;
            end else begin
              state_nxt = S_RAMP;
              en_nxt    = 1'b1;
              tick_nxt  = '0;
            end
          end
        end
        S_RUN: begin
          if (accept) begin
            if (cmd_dir != pwm_dir) begin
              if (pwm_duty != '0) begin
                state_nxt = S_BRAKE;
                tick_nxt  = '0;
              end else begin
                state_nxt = S_DEAD;
                en_nxt    = 1'b0;
                dead_nxt  = '0;
              end
            end else if (cmd_duty != pwm_duty) begin
              state_nxt = S_RAMP;
              tick_nxt  = '0;
            end
          end
        end
        S_RAMP: begin
          if (tick) begin
            tick_nxt = '0;
            duty_nxt = ramp_duty;
            if (ramp_duty == tgt_duty) begin
              if (tgt_duty != '0) begin
                state_nxt = S_RUN;
              end else begin
                state_nxt = S_IDLE;
                en_nxt    = 1'b0;
              end
            end
          end else begin
            tick_nxt = tick_cnt + TICK_W'(1);
          end
        end
        S_BRAKE: begin
          if (tick) begin
            tick_nxt = '0;
            duty_nxt = brake_duty;
            if (brake_duty == '0) begin
              state_nxt = S_DEAD;
              en_nxt    = 1'b0;
              dead_nxt  = '0;
            end
          end else begin
            tick_nxt = tick_cnt + TICK_W'(1);
          end
        end
        S_DEAD: begin
          en_nxt = 1'b0;
          if (dead_cnt == DEAD_LAST) begin
            dir_nxt = tgt_dir;
            if (tgt_duty != '0) begin
              state_nxt = S_RAMP;
              en_nxt    = 1'b1;
              tick_nxt  = '0;
            end else begin
              state_nxt = S_IDLE;
            end
          end else begin
            dead_nxt = dead_cnt + DEAD_W'(1);
          end
        end
        S_ESTOP: begin
          state_nxt = S_IDLE;
        end
        default: begin
          state_nxt = S_IDLE;
          duty_nxt  = '0;
          en_nxt    = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; reset drops the bridge immediately, no ramp-down.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state    <= S_IDLE;
      pwm_duty <= '0;
      pwm_dir  <= 1'b1;
      pwm_en   <= 1'b0;
      tick_cnt <= '0;
      dead_cnt <= '0;
      tgt_dir  <= 1'b1;
      tgt_duty <= '0;
      step     <= DUTY_W'(1);
    end else begin
      state    <= state_nxt;
      pwm_duty <= duty_nxt;
      pwm_dir  <= dir_nxt;
      pwm_en   <= en_nxt;
      tick_cnt <= tick_nxt;
      dead_cnt <= dead_nxt;
      tgt_dir  <= tgt_dir_nxt;
      tgt_duty <= tgt_duty_nxt;
      step     <= step_nxt;
    end
  end

endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// tb_motor_cmd_sequencer: directed scenarios followed by random commands,
// estop pulses and resets. Every cycle is compared against a timeline model
// that plans each command's expected per-clock outputs.
module tb_motor_cmd_sequencer;

  localparam int RD = 4;   // RAMP_DIV
  localparam int DT = 3;   // DEADTIME

  logic       tb_ACLK;
  logic       ARESET;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_dir;
  logic [7:0] cmd_duty;
  logic [7:0] cmd_step;
  logic       estop;
  logic [7:0] pwm_duty;
  logic       pwm_dir;
  logic       pwm_en;
  logic       busy;
  logic       fault;

  motor_cmd_sequencer #(.DUTY_W(8), .RAMP_DIV(RD), .DEADTIME(DT)) dut (
    .ACLK      (tb_ACLK),
    .ARESET    (ARESET),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_duty  (cmd_duty),
    .cmd_step  (cmd_step),
    .estop     (estop),
    .pwm_duty  (pwm_duty),
    .pwm_dir   (pwm_dir),
    .pwm_en    (pwm_en),
    .busy      (busy),
    .fault     (fault)
  );

  initial tb_ACLK = 1'b0;
  always #5 tb_ACLK = ~tb_ACLK;

  typedef struct packed {
    logic [7:0] duty;
    logic       en;
    logic       dir;
    logic       busy;
  } obs_t;

  obs_t q[$];     // planned outputs, one entry per upcoming clock edge
  obs_t cur;      // outputs expected right now
  logic m_fault;
  int   n_checks;
  int   n_fail;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push(input int duty, input logic en, input logic dir, input logic bsy, input int n);
    obs_t o;
    o.duty = 8'(duty);
    o.en   = en;
    o.dir  = dir;
    o.busy = bsy;
    for (int i = 0; i < n; i++) q.push_back(o);
  endtask

  // Ramp from 'from' to 'to': the entry edge, then a new value every RD clocks.
  task automatic plan_ramp(input logic dir, input int from, input int to, input int s);
    int v;
    v = from;
    push(v, 1'b1, dir, 1'b1, 1);
    while (v != to) begin
      push(v, 1'b1, dir, 1'b1, RD - 1);
      if (to > v) v = (v + s > to) ? to : v + s;
      else        v = (v - s < to) ? to : v - s;
      if (v == to) push(v, to != 0, dir, 1'b0, 1);
      else         push(v, 1'b1, dir, 1'b1, 1);
    end
  endtask

  // Dead-time with the bridge off, then the direction flips and we ramp or idle.
  task automatic plan_dead(input logic p, input logic d, input int t, input int s);
    push(0, 1'b0, p, 1'b1, DT);
    if (t > 0) plan_ramp(d, 0, t, s);
    else       push(0, 1'b0, d, 1'b0, 1);
  endtask

  task automatic plan_brake(input logic p, input int c, input logic d, input int t, input int s);
    int v;
    v = c;
    push(v, 1'b1, p, 1'b1, 1);
    while (v > 0) begin
      push(v, 1'b1, p, 1'b1, RD - 1);
      v = (v > s) ? v - s : 0;
      if (v > 0) push(v, 1'b1, p, 1'b1, 1);
    end
    plan_dead(p, d, t, s);
  endtask

  task automatic plan_cmd(input logic d, input logic [7:0] du, input logic [7:0] st);
    int s, t, c;
    logic p;
    s = (st == 8'd0) ? 1 : int'(st);
    t = int'(du);
    c = int'(cur.duty);
    p = cur.dir;
    if (c == 0) begin
      if (t != 0) begin
        if (d != p) plan_dead(p, d, t, s);
        else        plan_ramp(d, 0, t, s);
      end
    end else begin
      if (d != p)      plan_brake(p, c, d, t, s);
      else if (t != c) plan_ramp(d, c, t, s);
    end
  endtask

  // One clock: drive inputs, check cmd_ready, clock, advance model, check outputs.
  task automatic cyc(input logic v, input logic d, input logic [7:0] du, input logic [7:0] st,
                     input logic es, input logic rs);
    logic rdy;
    cmd_valid = v;
    cmd_dir   = d;
    cmd_duty  = du;
    cmd_step  = st;
    estop     = es;
    ARESET    = rs;
    #1;
    rdy = !rs && !es && !m_fault && (q.size() == 0);
    check_eq("cmd_ready", cmd_ready, rdy);
    @(posedge tb_ACLK);
    if (rs) begin
      q.delete();
      cur.duty = 8'h00; cur.en = 1'b0; cur.dir = 1'b1; cur.busy = 1'b0;
      m_fault = 1'b0;
    end else if (es) begin
      q.delete();
      cur.duty = 8'h00; cur.en = 1'b0; cur.busy = 1'b0;
      m_fault = 1'b1;
    end else if (m_fault) begin
      m_fault = 1'b0;
    end else begin
      if (v && rdy) plan_cmd(d, du, st);
      if (q.size() > 0) cur = q.pop_front();
    end
    #1;
    check_eq("pwm_duty", pwm_duty, cur.duty);
    check_eq("pwm_en",   pwm_en,   cur.en);
    check_eq("pwm_dir",  pwm_dir,  cur.dir);
    check_eq("busy",     busy,     cur.busy);
    check_eq("fault",    fault,    m_fault);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic settle(input int maxc);
    int n;
    n = 0;
    while ((q.size() > 0 || m_fault) && n < maxc) begin
      idle(1);
      n++;
    end
    check_eq("settle_busy", busy, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int es_left;
    logic es, rs, v, d;
    logic [7:0] du, st;
    n_checks = 0;
    n_fail   = 0;
    m_fault  = 1'b0;
    cur.duty = 8'h00; cur.en = 1'b0; cur.dir = 1'b1; cur.busy = 1'b0;

    // Reset, then a forward ramp to 0x40 in 0x10 steps
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    check_eq("rst_duty", pwm_duty, 8'h00);
    check_eq("rst_dir",  pwm_dir,  1'b1);
    check_eq("rst_en",   pwm_en,   1'b0);
    cyc(1'b1, 1'b1, 8'h40, 8'h10, 1'b0, 1'b0);
    check_eq("s1_en_at_accept", pwm_en, 1'b1);
    idle(4);
    check_eq("s1_first_tick", pwm_duty, 8'h10);
    settle(100);
    check_eq("s1_final", pwm_duty, 8'h40);

    // Saturating step: 0x40 -> 0x45 with step 0x10
    cyc(1'b1, 1'b1, 8'h45, 8'h10, 1'b0, 1'b0);
    settle(100);
    check_eq("s2_sat", pwm_duty, 8'h45);

    // Back to 0x40, then reverse to 0x20 with step 0x20
    cyc(1'b1, 1'b1, 8'h40, 8'h10, 1'b0, 1'b0);
    settle(100);
    cyc(1'b1, 1'b0, 8'h20, 8'h20, 1'b0, 1'b0);
    settle(200);
    check_eq("s3_dir", pwm_dir, 1'b0);
    check_eq("s3_duty", pwm_duty, 8'h20);

    // estop mid-ramp at 0x30, with a command offered during estop
    cyc(1'b1, 1'b0, 8'h40, 8'h10, 1'b0, 1'b0);
    for (int i = 0; i < 40 && cur.duty != 8'h30; i++) idle(1);
    check_eq("s4_at_30", pwm_duty, 8'h30);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    check_eq("s4_fault", fault, 1'b1);
    check_eq("s4_en_off", pwm_en, 1'b0);
    cyc(1'b1, 1'b0, 8'h55, 8'h01, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 8'h66, 8'h02, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    check_eq("s4_fault_clear", fault, 1'b0);
    check_eq("s4_duty_zero", pwm_duty, 8'h00);

    // step 0 behaves as step 1
    cyc(1'b1, cur.dir, 8'h03, 8'h00, 1'b0, 1'b0);
    idle(4);
    check_eq("s5_step1", pwm_duty, 8'h01);
    settle(100);
    check_eq("s5_final", pwm_duty, 8'h03);

    // Reset mid-brake at 0x80, then scenario 1 again
    cyc(1'b1, 1'b0, 8'h80, 8'h40, 1'b0, 1'b0);
    settle(100);
    cyc(1'b1, 1'b1, 8'h10, 8'h01, 1'b0, 1'b0);
    idle(2);
    check_eq("s6_braking", busy, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    check_eq("s6_rst_duty", pwm_duty, 8'h00);
    check_eq("s6_rst_en",   pwm_en,   1'b0);
    check_eq("s6_rst_dir",  pwm_dir,  1'b1);
    cyc(1'b1, 1'b1, 8'h40, 8'h10, 1'b0, 1'b0);
    settle(100);
    check_eq("s6_final", pwm_duty, 8'h40);

    // Random commands, estop bursts and occasional resets
    es_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if (es_left == 0 && $urandom_range(0, 99) == 0) es_left = $urandom_range(1, 4);
      es = (es_left > 0);
      if (es_left > 0) es_left--;
      rs = ($urandom_range(0, 299) == 0);
      v  = ($urandom_range(0, 2) == 0);
      d  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0:       du = 8'h00;
        1:       du = 8'hFF;
        default: du = 8'($urandom_range(1, 255));
      endcase
      case ($urandom_range(0, 3))
        0:       st = 8'h00;
        1:       st = 8'hFF;
        default: st = 8'($urandom_range(1, 48));
      endcase
      cyc(v, d, du, st, es, rs);
    end
    settle(3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
